// File: rtl/dispatch_ctrl_if.sv
// Dispatch bus bundle: instruction queue, regfile read/rename, CDB, ROB and RS ports.
// The slave modport is the dispatch controller; the master is whatever drives it.
interface dispatch_ctrl_if #(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned N_RS  = 4,
    parameter int unsigned OP_W  = 7
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              flush_i;
    logic              iq_valid_i;
    logic              iq_ready_o;
    logic [OP_W-1:0]   iq_op_i;
    logic [REG_W-1:0]  iq_src1_i;
    logic [REG_W-1:0]  iq_src2_i;
    logic [REG_W-1:0]  iq_dest_i;
    logic              iq_has_dest_i;

    logic [REG_W-1:0]  rf_src_a_o;
    logic [REG_W-1:0]  rf_src_b_o;
    logic [DATA_W-1:0] rf_data_a_i;
    logic [DATA_W-1:0] rf_data_b_i;
    logic              rf_valid_a_i;
    logic              rf_valid_b_i;
    logic [TAG_W-1:0]  rf_tag_a_i;
    logic [TAG_W-1:0]  rf_tag_b_i;
    logic              rf_allocate_o;
    logic [REG_W-1:0]  rf_reg_allocate_o;
    logic [TAG_W-1:0]  rf_tag_in_o;

    logic              cdb_valid_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [DATA_W-1:0] cdb_data_i;

    logic              rob_commit_i;
    logic              rob_alloc_o;
    logic [TAG_W-1:0]  rob_alloc_tag_o;
    logic [REG_W-1:0]  rob_alloc_dest_o;

    logic [N_RS-1:0]   rs_free_i;
    logic [N_RS-1:0]   rs_we_o;
    logic [OP_W-1:0]   rs_op_o;
    logic [TAG_W-1:0]  rs_tag_o;
    logic [DATA_W-1:0] rs_vj_o;
    logic [DATA_W-1:0] rs_vk_o;
    logic [TAG_W-1:0]  rs_qj_o;
    logic [TAG_W-1:0]  rs_qk_o;
    logic              rs_rj_o;
    logic              rs_rk_o;

    modport slave (
        input  flush_i, iq_valid_i, iq_op_i, iq_src1_i, iq_src2_i, iq_dest_i, iq_has_dest_i,
        input  rf_data_a_i, rf_data_b_i, rf_valid_a_i, rf_valid_b_i, rf_tag_a_i, rf_tag_b_i,
        input  cdb_valid_i, cdb_tag_i, cdb_data_i, rob_commit_i, rs_free_i,
        output iq_ready_o, rf_src_a_o, rf_src_b_o, rf_allocate_o, rf_reg_allocate_o, rf_tag_in_o,
        output rob_alloc_o, rob_alloc_tag_o, rob_alloc_dest_o,
        output rs_we_o, rs_op_o, rs_tag_o, rs_vj_o, rs_vk_o, rs_qj_o, rs_qk_o, rs_rj_o, rs_rk_o
    );

    modport master (
        output flush_i, iq_valid_i, iq_op_i, iq_src1_i, iq_src2_i, iq_dest_i, iq_has_dest_i,
        output rf_data_a_i, rf_data_b_i, rf_valid_a_i, rf_valid_b_i, rf_tag_a_i, rf_tag_b_i,
        output cdb_valid_i, cdb_tag_i, cdb_data_i, rob_commit_i, rs_free_i,
        input  iq_ready_o, rf_src_a_o, rf_src_b_o, rf_allocate_o, rf_reg_allocate_o, rf_tag_in_o,
        input  rob_alloc_o, rob_alloc_tag_o, rob_alloc_dest_o,
        input  rs_we_o, rs_op_o, rs_tag_o, rs_vj_o, rs_vk_o, rs_qj_o, rs_qk_o, rs_rj_o, rs_rk_o
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: one instruction per cycle from the IQ into a free RS, with ROB tag
// allocation, dest rename and operand resolution (regfile or same-cycle CDB bypass).
module dispatch_ctrl #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH),
    parameter int unsigned N_RS      = 4,
    parameter int unsigned OP_W      = 7
) (
    input  logic           clk,
    input  logic           rst,
    dispatch_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = TAG_W + 1;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ready_c;
    logic              fire_c;
    logic              commit_c;
    logic [N_RS-1:0]   rs_sel_c;
    logic [DATA_W-1:0] vj_c, vk_c;
    logic [TAG_W-1:0]  qj_c, qk_c;
    logic              rj_c, rk_c;

    // Operand source priority: x0, regfile value, CDB bypass, else wait on producer tag.
    function automatic void resolve(
        input  logic [REG_W-1:0]  src,
        input  logic              rf_valid,
        input  logic [DATA_W-1:0] rf_data,
        input  logic [TAG_W-1:0]  rf_tag,
        input  logic              cdb_valid,
        input  logic [TAG_W-1:0]  cdb_tag,
        input  logic [DATA_W-1:0] cdb_data,
        output logic [DATA_W-1:0] val,
        output logic [TAG_W-1:0]  q,
        output logic              rdy
    );
        val = '0;
        q   = '0;
        rdy = 1'b1;
        if (src == '0) begin
            val = '0;
        end else if (rf_valid) begin
            val = rf_data;
        end else if (cdb_valid && (cdb_tag == rf_tag)) begin
            val = cdb_data;
        end else begin
            rdy = 1'b0;
            q   = rf_tag;
        end
    endfunction

    assign ready_c  = !rst && (state_q == S_RUN) && !bus.flush_i &&
                      (count_q < CNT_W'(ROB_DEPTH)) && (|bus.rs_free_i);
    assign fire_c   = bus.iq_valid_i && ready_c;
    assign commit_c = bus.rob_commit_i && (count_q != '0);
    // Isolate the lowest set bit of the free mask.
    assign rs_sel_c = bus.rs_free_i & (~bus.rs_free_i + N_RS'(1));

    always_comb begin
        resolve(bus.iq_src1_i, bus.rf_valid_a_i, bus.rf_data_a_i, bus.rf_tag_a_i,
                bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_data_i, vj_c, qj_c, rj_c);
        resolve(bus.iq_src2_i, bus.rf_valid_b_i, bus.rf_data_b_i, bus.rf_tag_b_i,
                bus.cdb_valid_i, bus.cdb_tag_i, bus.cdb_data_i, vk_c, qk_c, rk_c);
    end

    // Next state: flush beats dispatch and commit; FLUSH always falls back to RUN.
    always_comb begin
        state_d = S_RUN;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_i) begin
            state_d = S_FLUSH;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (fire_c) begin
                tail_d = tail_q + TAG_W'(1);
            end
            if (fire_c && !commit_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!fire_c && commit_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Zero-latency dispatch side effects; everything held at zero during reset.
    always_comb begin
        bus.iq_ready_o        = ready_c;
        bus.rf_src_a_o        = '0;
        bus.rf_src_b_o        = '0;
        bus.rf_allocate_o     = 1'b0;
        bus.rf_reg_allocate_o = '0;
        bus.rf_tag_in_o       = '0;
        bus.rob_alloc_o       = 1'b0;
        bus.rob_alloc_tag_o   = '0;
        bus.rob_alloc_dest_o  = '0;
        bus.rs_we_o           = '0;
        bus.rs_op_o           = '0;
        bus.rs_tag_o          = '0;
        bus.rs_vj_o           = '0;
        bus.rs_vk_o           = '0;
        bus.rs_qj_o           = '0;
        bus.rs_qk_o           = '0;
        bus.rs_rj_o           = 1'b0;
        bus.rs_rk_o           = 1'b0;
        if (!rst) begin
            bus.rf_src_a_o        = bus.iq_src1_i;
            bus.rf_src_b_o        = bus.iq_src2_i;
            bus.rf_allocate_o     = fire_c && bus.iq_has_dest_i && (bus.iq_dest_i != '0);
            bus.rf_reg_allocate_o = bus.iq_dest_i;
            bus.rf_tag_in_o       = tail_q;
            bus.rob_alloc_o       = fire_c;
            bus.rob_alloc_tag_o   = tail_q;
            bus.rob_alloc_dest_o  = bus.iq_has_dest_i ? bus.iq_dest_i : '0;
            bus.rs_we_o           = fire_c ? rs_sel_c : '0;
            bus.rs_op_o           = bus.iq_op_i;
            bus.rs_tag_o          = tail_q;
            bus.rs_vj_o           = vj_c;
            bus.rs_vk_o           = vk_c;
            bus.rs_qj_o           = qj_c;
            bus.rs_qk_o           = qk_c;
            bus.rs_rj_o           = rj_c;
            bus.rs_rk_o           = rk_c;
        end
    end

    // A retire with nothing in flight means the ROB and this block disagree on occupancy.
    a_commit_nonempty: assert property (@(posedge clk) disable iff (rst)
        !(bus.rob_commit_i && !bus.flush_i && (count_q == '0)))
        else $error("rob_commit with empty ROB");

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios with literal expectations, then random traffic,
// all checked each cycle against a tail/count/flush reference model.
module tb_dispatch_ctrl;
    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned N_RS      = 4;
    localparam int unsigned OP_W      = 7;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int   m_tail;
    int   m_count;
    bit   m_flushing;
    bit   e_ready;
    bit   e_fire;

    dispatch_ctrl_if #(.TAG_W(TAG_W), .N_RS(N_RS), .OP_W(OP_W)) dif ();

    dispatch_ctrl #(
        .ROB_DEPTH(ROB_DEPTH),
        .TAG_W    (TAG_W),
        .N_RS     (N_RS),
        .OP_W     (OP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N_RS-1:0] lowest(input logic [N_RS-1:0] m);
        logic [N_RS-1:0] r = '0;
        for (int i = 0; i < int'(N_RS); i++) begin
            if (m[i]) begin
                r[i] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    function automatic void opnd(input logic [4:0] src, input logic vld, input logic [31:0] d,
                                 input logic [TAG_W-1:0] t, output logic [31:0] val,
                                 output bit rdy, output logic [TAG_W-1:0] q);
        val = 32'd0;
        rdy = 1'b1;
        q   = '0;
        if (src == 5'd0)                                      val = 32'd0;
        else if (vld)                                         val = d;
        else if (dif.cdb_valid_i && dif.cdb_tag_i == t)       val = dif.cdb_data_i;
        else begin
            rdy = 1'b0;
            q   = t;
        end
    endfunction

    task automatic idle();
        dif.flush_i       = 1'b0;
        dif.iq_valid_i    = 1'b0;
        dif.iq_op_i       = '0;
        dif.iq_src1_i     = '0;
        dif.iq_src2_i     = '0;
        dif.iq_dest_i     = '0;
        dif.iq_has_dest_i = 1'b0;
        dif.rf_data_a_i   = 32'h1111_0000;
        dif.rf_data_b_i   = 32'h2222_0000;
        dif.rf_valid_a_i  = 1'b1;
        dif.rf_valid_b_i  = 1'b1;
        dif.rf_tag_a_i    = '0;
        dif.rf_tag_b_i    = '0;
        dif.cdb_valid_i   = 1'b0;
        dif.cdb_tag_i     = '0;
        dif.cdb_data_i    = '0;
        dif.rob_commit_i  = 1'b0;
        dif.rs_free_i     = 4'hF;
    endtask

    // Compare every output against the model, just after the inputs have settled.
    task automatic sample();
        logic [31:0]      v;
        bit               r;
        logic [TAG_W-1:0] q;
        bit               e_alloc;
        #1;
        e_ready = !rst && !m_flushing && !dif.flush_i && (m_count < ROB_DEPTH) &&
                  (dif.rs_free_i != '0);
        e_fire  = e_ready && dif.iq_valid_i;
        e_alloc = e_fire && dif.iq_has_dest_i && (dif.iq_dest_i != 5'd0);
        chk("iq_ready", 32'(dif.iq_ready_o), 32'(e_ready));
        chk("rob_alloc", 32'(dif.rob_alloc_o), 32'(e_fire));
        chk("rs_we", 32'(dif.rs_we_o), e_fire ? 32'(lowest(dif.rs_free_i)) : 32'd0);
        chk("rf_allocate", 32'(dif.rf_allocate_o), 32'(e_alloc));
        if (rst) begin
            chk("rst_rf_src_a", 32'(dif.rf_src_a_o), 32'd0);
            chk("rst_rs_vj", dif.rs_vj_o, 32'd0);
        end else begin
            chk("rf_src_a", 32'(dif.rf_src_a_o), 32'(dif.iq_src1_i));
            chk("rf_src_b", 32'(dif.rf_src_b_o), 32'(dif.iq_src2_i));
        end
        if (e_fire) begin
            chk("rob_alloc_tag", 32'(dif.rob_alloc_tag_o), 32'(m_tail));
            chk("rs_tag", 32'(dif.rs_tag_o), 32'(m_tail));
            chk("rf_tag_in", 32'(dif.rf_tag_in_o), 32'(m_tail));
            chk("rs_op", 32'(dif.rs_op_o), 32'(dif.iq_op_i));
            chk("rob_alloc_dest", 32'(dif.rob_alloc_dest_o),
                dif.iq_has_dest_i ? 32'(dif.iq_dest_i) : 32'd0);
            if (e_alloc) chk("rf_reg_allocate", 32'(dif.rf_reg_allocate_o), 32'(dif.iq_dest_i));
            opnd(dif.iq_src1_i, dif.rf_valid_a_i, dif.rf_data_a_i, dif.rf_tag_a_i, v, r, q);
            chk("rs_rj", 32'(dif.rs_rj_o), 32'(r));
            chk("rs_qj", 32'(dif.rs_qj_o), 32'(q));
            if (r) chk("rs_vj", dif.rs_vj_o, v);
            opnd(dif.iq_src2_i, dif.rf_valid_b_i, dif.rf_data_b_i, dif.rf_tag_b_i, v, r, q);
            chk("rs_rk", 32'(dif.rs_rk_o), 32'(r));
            chk("rs_qk", 32'(dif.rs_qk_o), 32'(q));
            if (r) chk("rs_vk", dif.rs_vk_o, v);
        end
    endtask

    // Apply this cycle's inputs to the model, then move to the next driving point.
    task automatic advance();
        if (rst) begin
            m_tail = 0; m_count = 0; m_flushing = 1'b0;
        end else if (dif.flush_i) begin
            m_tail = 0; m_count = 0; m_flushing = 1'b1;
        end else begin
            m_flushing = 1'b0;
            if (e_fire) m_tail = (m_tail + 1) % ROB_DEPTH;
            m_count = m_count + (e_fire ? 1 : 0) - ((dif.rob_commit_i && m_count > 0) ? 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        m_tail = 0; m_count = 0; m_flushing = 1'b0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        sample();
        chk("lit_rst_ready", 32'(dif.iq_ready_o), 32'd0);
        advance();
        step();
        rst = 1'b0;
        sample();
        chk("lit_idle_ready", 32'(dif.iq_ready_o), 32'd1);
        advance();

        // Fill the ROB back-to-back
        for (int i = 0; i < 8; i++) begin
            dif.iq_valid_i    = 1'b1;
            dif.iq_has_dest_i = 1'b1;
            dif.iq_dest_i     = 5'(i + 1);
            dif.iq_src1_i     = 5'(i);
            dif.iq_src2_i     = 5'(i + 2);
            dif.iq_op_i       = 7'(i * 9);
            sample();
            chk("lit_fill_tag", 32'(dif.rob_alloc_tag_o), 32'(i));
            advance();
        end
        sample();
        chk("lit_full_ready", 32'(dif.iq_ready_o), 32'd0);
        chk("lit_full_count", 32'(m_count), 32'd8);
        advance();
        dif.iq_valid_i   = 1'b0;
        dif.rob_commit_i = 1'b1;
        step();
        dif.rob_commit_i = 1'b0;
        dif.iq_valid_i   = 1'b1;
        sample();
        chk("lit_wrap_ready", 32'(dif.iq_ready_o), 32'd1);
        chk("lit_wrap_tag", 32'(dif.rob_alloc_tag_o), 32'd0);
        advance();

        // Drain to 5, then fire+commit together against a sparse free mask
        dif.iq_valid_i   = 1'b0;
        dif.rob_commit_i = 1'b1;
        repeat (3) step();
        dif.iq_valid_i = 1'b1;
        dif.rs_free_i  = 4'b1010;
        sample();
        chk("lit_rs_we_1010", 32'(dif.rs_we_o), 32'h2);
        advance();
        chk("lit_count_fire_commit", 32'(m_count), 32'd5);
        dif.rob_commit_i = 1'b0;
        dif.rs_free_i    = 4'b0000;
        sample();
        chk("lit_norsv_ready", 32'(dif.iq_ready_o), 32'd0);
        chk("lit_norsv_alloc", 32'({dif.rob_alloc_o, dif.rf_allocate_o, dif.rs_we_o}), 32'd0);
        advance();

        // CDB bypass hit and miss
        dif.rs_free_i    = 4'hF;
        dif.rob_commit_i = 1'b1;
        dif.iq_src1_i    = 5'd5;
        dif.rf_valid_a_i = 1'b0;
        dif.rf_tag_a_i   = 3'd3;
        dif.cdb_valid_i  = 1'b1;
        dif.cdb_tag_i    = 3'd3;
        dif.cdb_data_i   = 32'hDEAD;
        sample();
        chk("lit_cdb_vj", dif.rs_vj_o, 32'hDEAD);
        chk("lit_cdb_rj", 32'(dif.rs_rj_o), 32'd1);
        advance();
        dif.cdb_tag_i = 3'd4;
        sample();
        chk("lit_cdb_miss_rj", 32'(dif.rs_rj_o), 32'd0);
        chk("lit_cdb_miss_qj", 32'(dif.rs_qj_o), 32'd3);
        advance();

        // add x0,x0,x0
        dif.iq_src1_i     = 5'd0;
        dif.iq_src2_i     = 5'd0;
        dif.iq_dest_i     = 5'd0;
        dif.iq_has_dest_i = 1'b1;
        dif.rf_valid_b_i  = 1'b0;
        dif.rf_tag_b_i    = 3'd6;
        dif.cdb_valid_i   = 1'b0;
        sample();
        chk("lit_x0_rdy", 32'({dif.rs_rj_o, dif.rs_rk_o}), 32'd3);
        chk("lit_x0_vals", dif.rs_vj_o | dif.rs_vk_o, 32'd0);
        chk("lit_x0_rfalloc", 32'(dif.rf_allocate_o), 32'd0);
        chk("lit_x0_roballoc", 32'(dif.rob_alloc_o), 32'd1);
        advance();

        // Flush at count 5 with a pending instruction
        chk("lit_pre_flush_count", 32'(m_count), 32'd5);
        dif.rob_commit_i = 1'b0;
        dif.flush_i      = 1'b1;
        sample();
        chk("lit_flush_nofire", 32'(dif.rob_alloc_o), 32'd0);
        advance();
        dif.flush_i = 1'b0;
        sample();
        chk("lit_flushstate_ready", 32'(dif.iq_ready_o), 32'd0);
        advance();
        sample();
        chk("lit_post_flush_ready", 32'(dif.iq_ready_o), 32'd1);
        chk("lit_post_flush_tag", 32'(dif.rob_alloc_tag_o), 32'd0);
        advance();
        chk("lit_post_flush_count", 32'(m_count), 32'd1);

        // Random traffic
        repeat (3000) begin
            rst               = ($urandom_range(0, 199) == 0);
            dif.flush_i       = ($urandom_range(0, 39) == 0);
            dif.iq_valid_i    = ($urandom_range(0, 3) != 0);
            dif.iq_op_i       = 7'($urandom);
            dif.iq_src1_i     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            dif.iq_src2_i     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            dif.iq_dest_i     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            dif.iq_has_dest_i = 1'($urandom);
            dif.rf_data_a_i   = $urandom;
            dif.rf_data_b_i   = $urandom;
            dif.rf_valid_a_i  = 1'($urandom);
            dif.rf_valid_b_i  = 1'($urandom);
            dif.rf_tag_a_i    = 3'($urandom);
            dif.rf_tag_b_i    = 3'($urandom);
            dif.cdb_valid_i   = 1'($urandom);
            dif.cdb_tag_i     = ($urandom_range(0, 1) == 0) ? dif.rf_tag_a_i : 3'($urandom);
            dif.cdb_data_i    = $urandom;
            dif.rob_commit_i  = (m_count > 0) && ($urandom_range(0, 2) == 0);
            dif.rs_free_i     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
